// File: rtl/job_desc_manager.sv
// Walks a host job-descriptor list, prefetches payloads and hands them to kernels; JOB_DESC_STAT_EN adds counters.
// Latency: read request issues the cycle after a slot frees; payload is combinational in the grant cycle (job_start + 1).
// Backpressure: no reads while the buffer is full; job_start waits for new_job and the post-grant guard.
module job_desc_manager #(
  parameter int KERNEL_NUM = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  manager_start,
  input  logic                  run_mode,
  input  logic [63:0]           init_addr,
  input  logic                  new_job,
  input  logic                  job_done,
  output logic                  job_start,
  input  logic [KERNEL_NUM-1:0] kernel_start,
  output logic                  rd_req_valid,
  output logic [63:0]           rd_req_addr,
  input  logic                  rd_req_ready,
  input  logic                  rd_rsp_valid,
  input  logic [127:0]          rd_rsp_data,
  output logic [63:0]           payload_addr,
  output logic [KERNEL_NUM-1:0] payload_valid,
  output logic                  list_done
`ifdef JOB_DESC_STAT_EN
  ,
  output logic [31:0]           desc_fetch_cnt,
  output logic [31:0]           job_grant_cnt
`endif
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_END,
    S_DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [63:0]   cur_addr, cur_addr_nxt;
  logic          ms_q;
  logic          ms_rise;
  logic [63:0]   rsp_next;

  logic [63:0]   buf_mem [BUF_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          buf_empty, buf_full;
  logic          push, pop;

  logic [1:0]    guard;
  logic          grant_window;
  logic          job_start_set;

  assign ms_rise   = manager_start & ~ms_q;
  assign rsp_next  = rd_rsp_data[127:64];
  assign buf_empty = (count == '0);
  assign buf_full  = (count == FULL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      ms_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_addr <= cur_addr_nxt;
      ms_q     <= manager_start;
    end
  end

  // Dropping manager_start aborts; a read already handed off must be drained before IDLE.
  always_comb begin
    state_nxt    = state;
    cur_addr_nxt = cur_addr;
    push         = 1'b0;
    rd_req_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (ms_rise) begin
          cur_addr_nxt = init_addr;
          state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (!manager_start) begin
          state_nxt = S_IDLE;
        end else if (!buf_full) begin
          rd_req_valid = 1'b1;
          if (rd_req_ready) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!manager_start) begin
          state_nxt = rd_rsp_valid ? S_IDLE : S_DRAIN;
        end else if (rd_rsp_valid) begin
          push = 1'b1;
          if (rsp_next != '0) begin
            cur_addr_nxt = rsp_next;
            state_nxt    = S_REQ;
          end else if (run_mode) begin
            cur_addr_nxt = init_addr;
            state_nxt    = S_REQ;
          end else begin
            state_nxt = S_END;
          end
        end
      end
      S_END: begin
        if (!manager_start) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (rd_rsp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_req_addr = cur_addr;

  // The guard keeps a second job_start off until the dispatcher's busy view includes the last grant.
  assign job_start_set = manager_start && !buf_empty && new_job && (guard == 2'd0) && !job_start;
  assign pop           = grant_window && manager_start && !buf_empty && (kernel_start != '0);
  assign payload_valid = pop ? kernel_start : '0;
  assign payload_addr  = pop ? buf_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_start    <= 1'b0;
      grant_window <= 1'b0;
      guard        <= 2'd0;
    end else if (!manager_start) begin
      job_start    <= 1'b0;
      grant_window <= 1'b0;
      guard        <= 2'd0;
    end else begin
      job_start    <= job_start_set;
      grant_window <= job_start;
      if (job_start_set) guard <= 2'd2;
      else if (guard != 2'd0) guard <= guard - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (!manager_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= rd_rsp_data[63:0];
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_done <= 1'b0;
    end else if (!manager_start) begin
      list_done <= 1'b0;
    end else if (state == S_IDLE && ms_rise) begin
      list_done <= 1'b0;
    end else if (state == S_END && buf_empty && job_done) begin
      list_done <= 1'b1;
    end
  end

`ifdef JOB_DESC_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_fetch_cnt <= '0;
      job_grant_cnt  <= '0;
    end else if (ms_rise) begin
      desc_fetch_cnt <= '0;
      job_grant_cnt  <= '0;
    end else begin
      if (push) desc_fetch_cnt <= desc_fetch_cnt + 32'd1;
      if (pop)  job_grant_cnt  <= job_grant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_job_desc_manager.sv
// Scoreboarded bench: directed descriptor lists, a memory responder and a scripted dispatcher.
module tb_job_desc_manager;

  localparam int KN = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          manager_start, run_mode, new_job, job_done;
  logic          job_start, rd_req_valid, rd_req_ready, rd_rsp_valid, list_done;
  logic [63:0]   init_addr, rd_req_addr, payload_addr;
  logic [KN-1:0] kernel_start, payload_valid;
  logic [127:0]  rd_rsp_data;
`ifdef JOB_DESC_STAT_EN
  logic [31:0]   desc_fetch_cnt, job_grant_cnt;
`endif

  typedef struct packed {
    logic [KN-1:0] mask;
    logic [63:0]   addr;
  } pay_t;

  logic [63:0]   exp_req [$];
  pay_t          exp_pay [$];
  logic [KN-1:0] grant_q [$];
  logic [127:0]  mem [logic [63:0]];
  logic [63:0]   pay_tbl [3];

  int   vectors     = 0;
  int   miscompares = 0;
  int   hs_cnt      = 0;
  int   js_cnt      = 0;
  int   since_js    = 100;
  int   rsp_lat     = 4;
  logic strict      = 1'b1;

  always #5 clk = ~clk;

  job_desc_manager #(.KERNEL_NUM(KN), .BUF_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .manager_start (manager_start),
    .run_mode      (run_mode),
    .init_addr     (init_addr),
    .new_job       (new_job),
    .job_done      (job_done),
    .job_start     (job_start),
    .kernel_start  (kernel_start),
    .rd_req_valid  (rd_req_valid),
    .rd_req_addr   (rd_req_addr),
    .rd_req_ready  (rd_req_ready),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),
    .payload_addr  (payload_addr),
    .payload_valid (payload_valid),
    .list_done     (list_done)
`ifdef JOB_DESC_STAT_EN
    ,
    .desc_fetch_cnt(desc_fetch_cnt),
    .job_grant_cnt (job_grant_cnt)
`endif
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin : monitor
    pay_t e;
    if (rst_n) begin
      if (rd_req_valid && rd_req_ready) begin
        hs_cnt++;
        if (exp_req.size() > 0) begin
          chk("req_addr", rd_req_addr, exp_req.pop_front());
        end else if (strict) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got %0h, expected none", rd_req_addr);
        end
      end
      if (payload_valid != '0) begin
        if (exp_pay.size() > 0) begin
          e = exp_pay.pop_front();
          chk("pay_mask", 64'(payload_valid), 64'(e.mask));
          chk("pay_addr", payload_addr, e.addr);
        end else if (strict) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pay: got %0h/%0h, expected none", payload_valid, payload_addr);
        end
      end
      if (job_start) begin
        js_cnt++;
        chk("job_start_gap_ge3", 64'(since_js >= 2), 64'd1);
        since_js = 0;
      end else begin
        since_js++;
      end
    end
  end

  // Host memory: one response per accepted request after rsp_lat cycles.
  initial begin : responder
    logic [63:0] a;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rd_req_valid && rd_req_ready) begin
        a = rd_req_addr;
        repeat (rsp_lat) @(posedge clk);
        #1;
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = mem.exists(a) ? mem[a] : '0;
        @(posedge clk);
        #1;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
      end
    end
  end

  // Dispatcher: answers each job_start one cycle later with the next scripted grant.
  initial begin : dispatcher
    logic [KN-1:0] g;
    kernel_start = '0;
    forever begin
      @(negedge clk);
      if (job_start) begin
        g = (grant_q.size() > 0) ? grant_q.pop_front() : KN'(1);
        @(posedge clk);
        #1 kernel_start = g;
        @(posedge clk);
        #1 kernel_start = '0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_list3(input int rounds, input bit zero_first);
    logic [KN-1:0] m;
    if (zero_first) grant_q.push_back('0);
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 3; k++) begin
        m = KN'(8'h80 >> k);
        exp_req.push_back(64'((k + 1) * 4096));
        grant_q.push_back(m);
        exp_pay.push_back('{m, pay_tbl[k]});
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_req.size() == 0 && exp_pay.size() == 0) break;
      @(negedge clk);
    end
    chk(name, 64'(exp_req.size() + exp_pay.size()), 64'd0);
  endtask

  task automatic stop_run();
    tick(1);
    manager_start = 1'b0;
    new_job       = 1'b0;
    job_done      = 1'b0;
    run_mode      = 1'b0;
    tick(12);
    exp_req.delete();
    exp_pay.delete();
    grant_q.delete();
  endtask

  initial begin : stimulus
    int  js0;
    int  hs1;
    logic seen;
    rst_n         = 1'b0;
    manager_start = 1'b0;
    run_mode      = 1'b0;
    init_addr     = 64'h1000;
    new_job       = 1'b0;
    job_done      = 1'b0;
    rd_req_ready  = 1'b1;
    pay_tbl[0] = 64'h0000_00AA_0000_0A01;
    pay_tbl[1] = 64'h0000_00AA_0000_0A02;
    pay_tbl[2] = 64'h0000_00AA_0000_0A03;
    mem[64'h1000] = {64'h2000, pay_tbl[0]};
    mem[64'h2000] = {64'h3000, pay_tbl[1]};
    mem[64'h3000] = {64'h0,    pay_tbl[2]};
    for (int k = 0; k < 5; k++) begin
      mem[64'h5000 + 64'(k * 4096)] = {(k == 4) ? 64'h0 : 64'h5000 + 64'((k + 1) * 4096),
                                       64'hBBBB_0000_0000_0000 + 64'(k)};
    end

    repeat (2) @(negedge clk);
    chk("rst_job_start",     64'(job_start),     64'd0);
    chk("rst_rd_req_valid",  64'(rd_req_valid),  64'd0);
    chk("rst_payload_valid", 64'(payload_valid), 64'd0);
    chk("rst_list_done",     64'(list_done),     64'd0);
    chk("rst_payload_addr",  payload_addr,       64'd0);
    chk("rst_rd_req_addr",   rd_req_addr,        64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single pass over the 3-descriptor list
    expect_list3(1, 1'b0);
    new_job       = 1'b1;
    manager_start = 1'b1;
    wait_drain("t1_drain", 300);
    tick(1);
    chk("t1_list_done_busy", 64'(list_done), 64'd0);
    job_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_list_done", 64'(list_done), 64'd1);
    stop_run();

    // Loop mode: the list is walked twice and never completes
    strict = 1'b0;
    run_mode = 1'b1;
    job_done = 1'b1;
    expect_list3(2, 1'b0);
    new_job       = 1'b1;
    manager_start = 1'b1;
    wait_drain("t2_drain", 500);
    chk("t2_list_done_loop", 64'(list_done), 64'd0);
    stop_run();
    strict = 1'b1;

    // No idle kernel: buffer fills, requests stall, dispatch follows new_job
    expect_list3(1, 1'b0);
    js0 = js_cnt;
    manager_start = 1'b1;
    tick(20);
    @(negedge clk);
    chk("t3_no_job_start", 64'(js_cnt), 64'(js0));
    chk("t3_req_stalled",  64'(rd_req_valid), 64'd0);
    chk("t3_prefetch_two", 64'(exp_req.size()), 64'd1);
    @(posedge clk);
    #1 new_job = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_job_start_next", 64'(job_start), 64'd1);
    wait_drain("t3_drain", 300);
    stop_run();

    // Empty grant: the head stays and is retried
    expect_list3(1, 1'b1);
    js0 = js_cnt;
    new_job       = 1'b1;
    manager_start = 1'b1;
    wait_drain("t4_drain", 300);
    tick(10);
    chk("t4_job_start_cnt", 64'(js_cnt - js0), 64'd4);
    stop_run();

    // Abort with a read outstanding; a rise during drain is ignored
    rsp_lat = 6;
    exp_req.push_back(64'h1000);
    manager_start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rd_req_valid && rd_req_ready;
    end
    chk("t5_first_req", 64'(seen), 64'd1);
    @(posedge clk);
    #1 manager_start = 1'b0;
    tick(1);
    manager_start = 1'b1;
    hs1 = hs_cnt;
    tick(14);
    @(negedge clk);
    chk("t5_drain_rise_ignored", 64'(hs_cnt), 64'(hs1));
    chk("t5_idle_no_req",        64'(rd_req_valid), 64'd0);
    tick(1);
    rsp_lat = 4;
    manager_start = 1'b0;
    tick(2);
    expect_list3(1, 1'b0);
    new_job       = 1'b1;
    manager_start = 1'b1;
    wait_drain("t5_restart_drain", 300);
    tick(1);
    job_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_list_done", 64'(list_done), 64'd1);
    stop_run();

`ifdef JOB_DESC_STAT_EN
    init_addr = 64'h5000;
    for (int k = 0; k < 5; k++) begin
      exp_req.push_back(64'h5000 + 64'(k * 4096));
      grant_q.push_back(KN'(1) << k);
      exp_pay.push_back('{KN'(1) << k, 64'hBBBB_0000_0000_0000 + 64'(k)});
    end
    new_job       = 1'b1;
    manager_start = 1'b1;
    wait_drain("t6_drain", 500);
    tick(5);
    chk("t6_desc_fetch_cnt", 64'(desc_fetch_cnt), 64'd5);
    chk("t6_job_grant_cnt",  64'(job_grant_cnt),  64'd5);
    manager_start = 1'b0;
    tick(2);
    strict = 1'b0;
    manager_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_desc_fetch_clr", 64'(desc_fetch_cnt), 64'd0);
    chk("t6_job_grant_clr",  64'(job_grant_cnt),  64'd0);
    stop_run();
    strict = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
